execution_muldiv_stage: RTL

Parametrised next-generation MIPS EX stage. Keeps the ALU, the forwarding muxes and the destination-register select. Adds registered EX/MEM outputs, HI/LO registers, and an iterative multiply/divide unit. Sits between the ID/EX and EX/MEM boundaries, and drives a stall request to the hazard unit.

---
 rtl/execution_muldiv_stage_if.sv | 50 +++++
 rtl/execution_muldiv_stage.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/execution_muldiv_stage_if.sv
// ID/EX -> EX stage bundle: operands, controls and forwarded values in, EX/MEM results, busy and stall out.
// The master side is the ID/EX boundary. The slave side is the EX stage.
interface execution_muldiv_stage_if #(
    parameter int NB_BITS       = 32,
    parameter int NB_ALU_OP_CTL = 4,
    parameter int NB_FUNCTION   = 6,
    parameter int NB_CTL        = 8,
    parameter int NB_REG        = 5
);
    logic                     i_valid;
    logic                     i_flush;
    logic [1:0]               i_mux_a_hz;
    logic [1:0]               i_mux_b_hz;
    logic [NB_BITS-1:0]       i_ex_mem_reg_hz;
    logic [NB_BITS-1:0]       i_mem_wb_reg_hz;
    logic [NB_ALU_OP_CTL-1:0] i_alu_op_ctl;
    logic [1:0]               i_mux_rs_ctl;
    logic                     i_mux_rt_ctl;
    logic                     i_mux_dest_ctl;
    logic [NB_REG-1:0]        i_rt;
    logic [NB_REG-1:0]        i_rd;
    logic [NB_BITS-1:0]       i_sign_ext;
    logic [NB_BITS-1:0]       i_rt_reg;
    logic [NB_BITS-1:0]       i_rs_reg;
    logic [NB_BITS-1:0]       i_pc_4;
    logic [NB_FUNCTION-1:0]   i_function;
    logic [NB_CTL-1:0]        i_wb_ctl;
    logic [NB_CTL-1:0]        i_mem_ctl;
    logic [NB_BITS-1:0]       o_alu_out;
    logic [NB_BITS-1:0]       o_data_reg;
    logic [NB_REG-1:0]        o_reg_dst;
    logic [NB_CTL-1:0]        o_wb_ctl;
    logic [NB_CTL-1:0]        o_mem_ctl;
    logic                     o_busy;
    logic                     o_stall;

    modport master (
        output i_valid, i_flush, i_mux_a_hz, i_mux_b_hz, i_ex_mem_reg_hz, i_mem_wb_reg_hz,
               i_alu_op_ctl, i_mux_rs_ctl, i_mux_rt_ctl, i_mux_dest_ctl, i_rt, i_rd,
               i_sign_ext, i_rt_reg, i_rs_reg, i_pc_4, i_function, i_wb_ctl, i_mem_ctl,
        input  o_alu_out, o_data_reg, o_reg_dst, o_wb_ctl, o_mem_ctl, o_busy, o_stall
    );

    modport slave (
        input  i_valid, i_flush, i_mux_a_hz, i_mux_b_hz, i_ex_mem_reg_hz, i_mem_wb_reg_hz,
               i_alu_op_ctl, i_mux_rs_ctl, i_mux_rt_ctl, i_mux_dest_ctl, i_rt, i_rd,
               i_sign_ext, i_rt_reg, i_rs_reg, i_pc_4, i_function, i_wb_ctl, i_mem_ctl,
        output o_alu_out, o_data_reg, o_reg_dst, o_wb_ctl, o_mem_ctl, o_busy, o_stall
    );
endinterface

// File: rtl/execution_muldiv_stage.sv
// MIPS EX stage: ALU, forwarding, HI/LO and iterative mul/div. EX/MEM results are registered 1 cycle later. MULDIV_FAST_MUL_EN selects a 1-cycle multiply.
// Backpressure: o_stall holds upstream while a HI/LO or mul/div op meets a busy unit.
module execution_muldiv_stage #(
    parameter int NB_BITS       = 32,
    parameter int NB_ALU_OP_CTL = 4,
    parameter int NB_FUNCTION   = 6,
    parameter int NB_CTL        = 8,
    parameter int NB_REG        = 5
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    execution_muldiv_stage_if.slave   bus
);
    localparam int CNT_W = $clog2(NB_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NB_BITS - 1);

    localparam logic [NB_ALU_OP_CTL-1:0] OP_ADD  = NB_ALU_OP_CTL'(0);
    localparam logic [NB_ALU_OP_CTL-1:0] OP_SUB  = NB_ALU_OP_CTL'(1);
    localparam logic [NB_ALU_OP_CTL-1:0] OP_FUNC = NB_ALU_OP_CTL'(2);
    localparam logic [NB_ALU_OP_CTL-1:0] OP_ANDI = NB_ALU_OP_CTL'(4);
    localparam logic [NB_ALU_OP_CTL-1:0] OP_ORI  = NB_ALU_OP_CTL'(5);
    localparam logic [NB_ALU_OP_CTL-1:0] OP_XORI = NB_ALU_OP_CTL'(6);
    localparam logic [NB_ALU_OP_CTL-1:0] OP_LUI  = NB_ALU_OP_CTL'(7);
    localparam logic [NB_ALU_OP_CTL-1:0] OP_SLTI = NB_ALU_OP_CTL'(8);
    localparam logic [NB_ALU_OP_CTL-1:0] OP_JAL  = NB_ALU_OP_CTL'(9);

    localparam logic [NB_FUNCTION-1:0] F_SLL   = NB_FUNCTION'(6'h00);
    localparam logic [NB_FUNCTION-1:0] F_SRL   = NB_FUNCTION'(6'h02);
    localparam logic [NB_FUNCTION-1:0] F_SRA   = NB_FUNCTION'(6'h03);
    localparam logic [NB_FUNCTION-1:0] F_SLLV  = NB_FUNCTION'(6'h04);
    localparam logic [NB_FUNCTION-1:0] F_SRLV  = NB_FUNCTION'(6'h06);
    localparam logic [NB_FUNCTION-1:0] F_SRAV  = NB_FUNCTION'(6'h07);
    localparam logic [NB_FUNCTION-1:0] F_JR    = NB_FUNCTION'(6'h08);
    localparam logic [NB_FUNCTION-1:0] F_JALR  = NB_FUNCTION'(6'h09);
    localparam logic [NB_FUNCTION-1:0] F_MFHI  = NB_FUNCTION'(6'h10);
    localparam logic [NB_FUNCTION-1:0] F_MTHI  = NB_FUNCTION'(6'h11);
    localparam logic [NB_FUNCTION-1:0] F_MFLO  = NB_FUNCTION'(6'h12);
    localparam logic [NB_FUNCTION-1:0] F_MTLO  = NB_FUNCTION'(6'h13);
    localparam logic [NB_FUNCTION-1:0] F_MULT  = NB_FUNCTION'(6'h18);
    localparam logic [NB_FUNCTION-1:0] F_MULTU = NB_FUNCTION'(6'h19);
    localparam logic [NB_FUNCTION-1:0] F_DIV   = NB_FUNCTION'(6'h1a);
    localparam logic [NB_FUNCTION-1:0] F_DIVU  = NB_FUNCTION'(6'h1b);
    localparam logic [NB_FUNCTION-1:0] F_ADDU  = NB_FUNCTION'(6'h21);
    localparam logic [NB_FUNCTION-1:0] F_SUBU  = NB_FUNCTION'(6'h23);
    localparam logic [NB_FUNCTION-1:0] F_AND   = NB_FUNCTION'(6'h24);
    localparam logic [NB_FUNCTION-1:0] F_OR    = NB_FUNCTION'(6'h25);
    localparam logic [NB_FUNCTION-1:0] F_XOR   = NB_FUNCTION'(6'h26);
    localparam logic [NB_FUNCTION-1:0] F_NOR   = NB_FUNCTION'(6'h27);
    localparam logic [NB_FUNCTION-1:0] F_SLT   = NB_FUNCTION'(6'h2a);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t                 state_q;
    logic                   busy_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [NB_BITS-1:0]     hi_q, lo_q;
    logic [NB_BITS-1:0]     acc_q, q_q, dvs_q;
    logic                   neg_q, rneg_q, div0_q, is_div_q;

    logic [NB_BITS-1:0]     alu_q, alu_d, data_q, data_d;
    logic [NB_REG-1:0]      dst_q, dst_d;
    logic [NB_CTL-1:0]      wb_q, wb_d, mem_q, mem_d;

    logic [NB_BITS-1:0]     fwd_rs, fwd_rt, op_a, op_b, alu_res;
    logic [4:0]             shamt;
    logic                   is_func, is_mul, is_div, is_mthi, is_mtlo, md_class;
    logic                   stall, live, start_mul, start_div, capture;
    logic                   signed_op, a_neg, b_neg;
    logic [NB_BITS-1:0]     a_mag, b_mag;
    logic [NB_BITS:0]       div_sh;
    logic                   div_ge;
    logic [NB_BITS-1:0]     div_sub;
    logic [2*NB_BITS-1:0]   prod, prod_s;
    logic [NB_BITS-1:0]     quo, rem;
`ifdef MULDIV_FAST_MUL_EN
    logic [2*NB_BITS-1:0]   mul_full;
`else
    logic [NB_BITS:0]       mul_sum;
`endif

    always_comb begin
        case (bus.i_mux_a_hz)
            2'b01:   fwd_rs = bus.i_ex_mem_reg_hz;
            2'b10:   fwd_rs = bus.i_mem_wb_reg_hz;
            default: fwd_rs = bus.i_rs_reg;
        endcase
        case (bus.i_mux_b_hz)
            2'b01:   fwd_rt = bus.i_ex_mem_reg_hz;
            2'b10:   fwd_rt = bus.i_mem_wb_reg_hz;
            default: fwd_rt = bus.i_rt_reg;
        endcase
        case (bus.i_mux_rs_ctl)
            2'b00:   op_a = bus.i_pc_4;
            2'b10:   op_a = bus.i_sign_ext;
            default: op_a = fwd_rs;
        endcase
        op_b  = bus.i_mux_rt_ctl ? bus.i_sign_ext : fwd_rt;
        shamt = op_a[4:0];
    end

    always_comb begin
        alu_res = '0;
        if (is_func) begin
            case (bus.i_function)
                F_SLL, F_SLLV: alu_res = op_b << shamt;
                F_SRL, F_SRLV: alu_res = op_b >> shamt;
                F_SRA, F_SRAV: alu_res = $signed(op_b) >>> shamt;
                F_JR:          alu_res = '0;
                F_JALR:        alu_res = op_a + NB_BITS'(4);
                F_ADDU:        alu_res = op_a + op_b;
                F_SUBU:        alu_res = op_a - op_b;
                F_AND:         alu_res = op_a & op_b;
                F_OR:          alu_res = op_a | op_b;
                F_XOR:         alu_res = op_a ^ op_b;
                F_NOR:         alu_res = ~(op_a | op_b);
                F_SLT:         alu_res = {{(NB_BITS-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
                F_MFHI:        alu_res = hi_q;
                F_MFLO:        alu_res = lo_q;
                default:       alu_res = '0;
            endcase
        end else begin
            case (bus.i_alu_op_ctl)
                OP_ADD:  alu_res = op_a + op_b;
                OP_SUB:  alu_res = op_a - op_b;
                OP_ANDI: alu_res = op_a & op_b;
                OP_ORI:  alu_res = op_a | op_b;
                OP_XORI: alu_res = op_a ^ op_b;
                OP_LUI:  alu_res = op_b << (NB_BITS / 2);
                OP_SLTI: alu_res = {{(NB_BITS-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
                OP_JAL:  alu_res = op_a + NB_BITS'(4);
                default: alu_res = '0;
            endcase
        end
    end

    // Any HI/LO-touching op must wait for the unit; plain ALU ops flow past it.
    assign is_func   = (bus.i_alu_op_ctl == OP_FUNC);
    assign is_mul    = is_func & ((bus.i_function == F_MULT) | (bus.i_function == F_MULTU));
    assign is_div    = is_func & ((bus.i_function == F_DIV)  | (bus.i_function == F_DIVU));
    assign is_mthi   = is_func & (bus.i_function == F_MTHI);
    assign is_mtlo   = is_func & (bus.i_function == F_MTLO);
    assign md_class  = is_mul | is_div | is_mthi | is_mtlo |
                       (is_func & ((bus.i_function == F_MFHI) | (bus.i_function == F_MFLO)));
    assign stall     = bus.i_valid & (state_q != S_IDLE) & md_class;
    assign live      = bus.i_valid & ~bus.i_flush & ~stall;
    assign start_mul = live & is_mul;
    assign start_div = live & is_div;
    assign capture   = live & ~(is_mul | is_div | is_mthi | is_mtlo);

    assign signed_op = is_func & ((bus.i_function == F_MULT) | (bus.i_function == F_DIV));
    assign a_neg     = signed_op & fwd_rs[NB_BITS-1];
    assign b_neg     = signed_op & fwd_rt[NB_BITS-1];
    assign a_mag     = a_neg ? -fwd_rs : fwd_rs;
    assign b_mag     = b_neg ? -fwd_rt : fwd_rt;

    assign div_sh  = {acc_q, q_q[NB_BITS-1]};
    assign div_ge  = (div_sh >= {1'b0, dvs_q});
    assign div_sub = div_sh[NB_BITS-1:0] - dvs_q;
`ifdef MULDIV_FAST_MUL_EN
    assign mul_full = {{NB_BITS{1'b0}}, dvs_q} * {{NB_BITS{1'b0}}, q_q};
`else
    assign mul_sum  = {1'b0, acc_q} + (q_q[0] ? {1'b0, dvs_q} : '0);
`endif

    // Divide by zero leaves |dividend| in acc, so only the quotient needs forcing.
    assign prod   = {acc_q, q_q};
    assign prod_s = neg_q ? -prod : prod;
    assign quo    = div0_q ? '1 : (neg_q ? -q_q : q_q);
    assign rem    = rneg_q ? -acc_q : acc_q;

    always_comb begin
        alu_d  = '0;
        data_d = '0;
        dst_d  = '0;
        wb_d   = '0;
        mem_d  = '0;
        if (capture) begin
            alu_d  = alu_res;
            data_d = fwd_rt;
            dst_d  = bus.i_mux_dest_ctl ? bus.i_rt : bus.i_rd;
            wb_d   = bus.i_wb_ctl;
            mem_d  = bus.i_mem_ctl;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            alu_q  <= '0;
            data_q <= '0;
            dst_q  <= '0;
            wb_q   <= '0;
            mem_q  <= '0;
        end else begin
            alu_q  <= alu_d;
            data_q <= data_d;
            dst_q  <= dst_d;
            wb_q   <= wb_d;
            mem_q  <= mem_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q  <= S_IDLE;
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            acc_q    <= '0;
            q_q      <= '0;
            dvs_q    <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            div0_q   <= 1'b0;
            is_div_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_mul | start_div) begin
                        state_q  <= start_mul ? S_MUL : S_DIV;
                        busy_q   <= 1'b1;
                        cnt_q    <= '0;
                        acc_q    <= '0;
                        q_q      <= start_mul ? b_mag : a_mag;
                        dvs_q    <= start_mul ? a_mag : b_mag;
                        neg_q    <= a_neg ^ b_neg;
                        rneg_q   <= a_neg;
                        div0_q   <= start_div & (fwd_rt == '0);
                        is_div_q <= start_div;
                    end
                    if (live & is_mthi) hi_q <= fwd_rs;
                    if (live & is_mtlo) lo_q <= fwd_rs;
                end
                S_MUL: begin
`ifdef MULDIV_FAST_MUL_EN
                    {acc_q, q_q} <= mul_full;
                    state_q      <= S_DONE;
                    busy_q       <= 1'b0;
`else
                    {acc_q, q_q} <= {mul_sum, q_q[NB_BITS-1:1]};
                    cnt_q        <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                    end
`endif
                end
                S_DIV: begin
                    acc_q <= div_ge ? div_sub : div_sh[NB_BITS-1:0];
                    q_q   <= {q_q[NB_BITS-2:0], div_ge};
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    hi_q    <= is_div_q ? rem : prod_s[2*NB_BITS-1:NB_BITS];
                    lo_q    <= is_div_q ? quo : prod_s[NB_BITS-1:0];
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.o_alu_out  = alu_q;
    assign bus.o_data_reg = data_q;
    assign bus.o_reg_dst  = dst_q;
    assign bus.o_wb_ctl   = wb_q;
    assign bus.o_mem_ctl  = mem_q;
    assign bus.o_busy     = busy_q;
    assign bus.o_stall    = stall;
endmodule
